// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU-side definitions for the DMG bus fabric.
// Holds the OAM DMA state encoding, the DMA register address, the OAM
// length, the high-page tag and the echo-RAM source folding helper.
package gb_cpu_common_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam int          OAM_LEN      = 160;
  localparam logic [7:0]  HI_PAGE      = 8'hFF;

  // Pages 0xE0-0xFF would land in echo RAM / OAM / IO; the DMA unit folds
  // them back onto WRAM (0xC0-0xDF) by clearing bit 5.
  function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
    return (src >= 8'hE0) ? (src & 8'hDF) : src;
  endfunction

endpackage

// File: rtl/gb_oam_dma_arbiter_if.sv
// Bundle of every CPU, main-bus, high-page and OAM signal around the
// OAM DMA arbiter.
//   slave  : the arbiter's view (CPU requests and read data in, strobes out)
//   master : the surrounding fabric's view (the opposite directions)
interface gb_oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_wdata;
  logic        hi_we;
  logic        hi_re;
  logic [7:0]  hi_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, bus_rdata, hi_rdata,
    output cpu_rdata, bus_addr, bus_wdata, bus_we, bus_re,
           hi_addr, hi_wdata, hi_we, hi_re,
           oam_addr, oam_wdata, oam_we, dma_active
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, bus_rdata, hi_rdata,
    input  cpu_rdata, bus_addr, bus_wdata, bus_we, bus_re,
           hi_addr, hi_wdata, hi_we, hi_re,
           oam_addr, oam_wdata, oam_we, dma_active
  );
endinterface

// File: rtl/gb_oam_dma_engine.sv
// OAM DMA sequencer: FSM, start-delay counter, byte index and the one-stage
// OAM write pipeline.
// Ports:
//   clk, reset_n  M-cycle clock, asynchronous active-low reset
//   reg_write     CPU write to the DMA register this cycle
//   reg_wdata     value written (source page)
//   bus_rdata     main bus read data for the current DMA address
//   src_reg       last written source page (readable by the CPU)
//   dma_addr      main bus address the DMA reads this cycle
//   dma_active    DMA owns the main bus (XFER state)
//   oam_addr/oam_wdata/oam_we  registered OAM write port
module gb_oam_dma_engine
  import gb_cpu_common_pkg::*;
#(
  parameter int DMA_LEN     = OAM_LEN,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_write,
  input  logic [7:0]  reg_wdata,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  src_reg,
  output logic [15:0] dma_addr,
  output logic        dma_active,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we
);

  localparam logic [7:0] LAST_IDX   = 8'(DMA_LEN - 1);
  localparam logic [3:0] DELAY_LOAD = 4'(START_DELAY);

  dma_state_t state;
  logic [7:0] idx;
  logic [3:0] delay;

  assign dma_addr = {dma_src_eff(src_reg), idx};

  // The byte read in an XFER cycle is written to OAM in the following
  // cycle. A restart discards the byte read in the restart cycle, but the
  // write already sitting in the output register still lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= DMA_IDLE;
      src_reg    <= 8'h00;
      idx        <= 8'h00;
      delay      <= 4'd0;
      dma_active <= 1'b0;
      oam_we     <= 1'b0;
      oam_addr   <= 8'h00;
      oam_wdata  <= 8'h00;
    end else begin
      oam_we <= 1'b0;
      if (state == DMA_XFER && !reg_write) begin
        oam_we    <= 1'b1;
        oam_addr  <= idx;
        oam_wdata <= bus_rdata;
      end

      if (reg_write) begin
        src_reg    <= reg_wdata;
        delay      <= DELAY_LOAD;
        idx        <= 8'h00;
        dma_active <= 1'b0;
        state      <= DMA_START;
      end else begin
        case (state)
          DMA_IDLE: begin
            dma_active <= 1'b0;
          end
          DMA_START: begin
            if (delay <= 4'd1) begin
              delay      <= 4'd0;
              idx        <= 8'h00;
              dma_active <= 1'b1;
              state      <= DMA_XFER;
            end else begin
              delay <= delay - 4'd1;
            end
          end
          DMA_XFER: begin
            if (idx == LAST_IDX) begin
              idx        <= 8'h00;
              dma_active <= 1'b0;
              state      <= DMA_IDLE;
            end else begin
              idx <= idx + 8'd1;
            end
          end
          default: begin
            dma_active <= 1'b0;
            state      <= DMA_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/gb_oam_dma_arbiter.sv
// OAM DMA arbiter: shares the main memory bus between the CPU and the OAM
// DMA engine and keeps the high page (0xFF00-0xFFFF) reachable by the CPU
// at all times.
// Ports:
//   clk, reset_n  M-cycle clock, asynchronous active-low reset
//   io            gb_oam_dma_arbiter_if.slave: CPU request/response, main
//                 bus, high-page bus, OAM write port and dma_active
module gb_oam_dma_arbiter
  import gb_cpu_common_pkg::*;
#(
  parameter int         DMA_LEN     = OAM_LEN,
  parameter int         START_DELAY = 1,
  parameter logic [7:0] OPEN_BUS    = 8'hFF
) (
  input logic                  clk,
  input logic                  reset_n,
  gb_oam_dma_arbiter_if.slave  io
);

  logic        is_dma_reg;
  logic        is_main;
  logic        is_hi;
  logic        cpu_main;
  logic        dma_reg_write;
  logic        dma_active;
  logic [7:0]  src_reg;
  logic [15:0] dma_addr;

  assign is_dma_reg    = (io.cpu_addr == DMA_REG_ADDR);
  assign is_main       = (io.cpu_addr[15:8] != HI_PAGE);
  assign is_hi         = !is_main && !is_dma_reg;
  assign cpu_main      = is_main && !dma_active;
  assign dma_reg_write = io.cpu_we && is_dma_reg;

  gb_oam_dma_engine #(
    .DMA_LEN     (DMA_LEN),
    .START_DELAY (START_DELAY)
  ) u_engine (
    .clk        (clk),
    .reset_n    (reset_n),
    .reg_write  (dma_reg_write),
    .reg_wdata  (io.cpu_wdata),
    .bus_rdata  (io.bus_rdata),
    .src_reg    (src_reg),
    .dma_addr   (dma_addr),
    .dma_active (dma_active),
    .oam_addr   (io.oam_addr),
    .oam_wdata  (io.oam_wdata),
    .oam_we     (io.oam_we)
  );

  // The DMA only reads, so the main-bus write strobe belongs to the CPU
  // alone and is simply suppressed while the DMA owns the bus.
  assign io.bus_addr   = dma_active ? dma_addr : io.cpu_addr;
  assign io.bus_wdata  = io.cpu_wdata;
  assign io.bus_we     = io.cpu_we && cpu_main;
  assign io.bus_re     = dma_active || (io.cpu_re && cpu_main);

  assign io.hi_addr    = io.cpu_addr[7:0];
  assign io.hi_wdata   = io.cpu_wdata;
  assign io.hi_we      = io.cpu_we && is_hi;
  assign io.hi_re      = io.cpu_re && is_hi;

  assign io.dma_active = dma_active;

  // CPU read data: the DMA register is answered locally, blocked main-bus
  // reads see the open-bus value.
  always_comb begin
    io.cpu_rdata = OPEN_BUS;
    if (is_dma_reg) begin
      io.cpu_rdata = src_reg;
    end else if (is_hi) begin
      io.cpu_rdata = io.hi_rdata;
    end else if (cpu_main) begin
      io.cpu_rdata = io.bus_rdata;
    end
  end

endmodule

// File: tb/tb_gb_oam_dma_arbiter.sv
// Self-checking bench for gb_oam_dma_arbiter: routing vector tables,
// full transfers, restart, echo folding and asynchronous reset mid-transfer.
module tb_gb_oam_dma_arbiter;
  import gb_cpu_common_pkg::*;

  localparam int LEN = 160;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic        exp_bus_we;
    logic        exp_bus_re;
    logic        exp_hi_we;
    logic        exp_hi_re;
    logic [7:0]  exp_hi_addr;
    logic [7:0]  exp_rdata;
    logic        exp_active;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } oam_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   oam_pulses = 0;
  int   base;

  vec_t     rt_q[$];
  oam_exp_t oam_q[$];
  vec_t     idle_vecs[9];
  vec_t     dma_vecs[5];

  always #5 clk = ~clk;

  gb_oam_dma_arbiter_if io();

  gb_oam_dma_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  // Memory models for the main bus and the high page.
  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[15:8] ^ {a[6:0], a[7]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] hi_model(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  function automatic logic [7:0] eff(input logic [7:0] s);
    return (s >= 8'hE0) ? (s & 8'hDF) : s;
  endfunction

  assign io.bus_rdata = mem_model(io.bus_addr);
  assign io.hi_rdata  = hi_model(io.hi_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    io.cpu_addr  = 16'h0000;
    io.cpu_wdata = 8'h00;
    io.cpu_we    = 1'b0;
    io.cpu_re    = 1'b0;
  endtask

  task automatic push_transfer(input logic [7:0] src);
    for (int i = 0; i < LEN; i++) begin
      oam_q.push_back('{addr: 8'(i), data: mem_model({eff(src), 8'(i)})});
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    io.cpu_addr  = v.addr;
    io.cpu_wdata = v.wdata;
    io.cpu_we    = v.we;
    io.cpu_re    = v.re;
    rt_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t v;
    if (rt_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL route_queue: got empty, expected a pending vector");
    end else begin
      v = rt_q.pop_front();
      chk("bus_we", io.bus_we, v.exp_bus_we);
      chk("bus_re", io.bus_re, v.exp_bus_re);
      chk("hi_we", io.hi_we, v.exp_hi_we);
      chk("hi_re", io.hi_re, v.exp_hi_re);
      chk("cpu_rdata", io.cpu_rdata, v.exp_rdata);
      chk("dma_active", io.dma_active, v.exp_active);
      if (v.exp_hi_we || v.exp_hi_re) chk("hi_addr", io.hi_addr, v.exp_hi_addr);
      if (v.exp_bus_we) chk("bus_wdata", io.bus_wdata, v.wdata);
    end
  endtask

  // Write the DMA register, then sit through the write and START cycles.
  task automatic start_dma(input logic [7:0] src);
    io.cpu_addr  = DMA_REG_ADDR;
    io.cpu_wdata = src;
    io.cpu_we    = 1'b1;
    io.cpu_re    = 1'b0;
    push_transfer(src);
    @(negedge clk);
    chk("write_cycle_active", io.dma_active, 1'b0);
    next_cycle();
    cpu_idle();
    @(negedge clk);
    chk("start_active", io.dma_active, 1'b0);
    chk("start_bus_re", io.bus_re, 1'b0);
    next_cycle();
  endtask

  task automatic xfer_cycles(input logic [7:0] src, input int first, input int count,
                             input bit use_vecs);
    for (int k = first; k < first + count; k++) begin
      bit vec_on;
      vec_on = use_vecs && k >= 20 && k < 25;
      if (vec_on) applyStimulus(dma_vecs[k - 20]);
      else cpu_idle();
      @(negedge clk);
      chk("dma_bus_addr", io.bus_addr, {eff(src), 8'(k)});
      chk("dma_bus_re", io.bus_re, 1'b1);
      chk("dma_active", io.dma_active, 1'b1);
      if (vec_on) checkOutput();
      next_cycle();
    end
    cpu_idle();
  endtask

  task automatic finish_transfer(input string name, input int expected_pulses);
    @(negedge clk);
    chk({name, "_done_active"}, io.dma_active, 1'b0);
    next_cycle();
    next_cycle();
    chk({name, "_oam_pending"}, oam_q.size(), 0);
    chk({name, "_oam_pulses"}, oam_pulses - base, expected_pulses);
  endtask

  // OAM scoreboard: every oam_we pulse must match the next expected write.
  always @(negedge clk) begin
    if (io.oam_we === 1'b1) begin
      oam_exp_t e;
      oam_pulses++;
      if (oam_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL oam_unexpected: got write addr 0x%0h, expected no write", io.oam_addr);
      end else begin
        e = oam_q.pop_front();
        chk("oam_addr", io.oam_addr, e.addr);
        chk("oam_wdata", io.oam_wdata, e.data);
      end
    end
  end

  initial begin
    idle_vecs[0] = '{16'hC123, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mem_model(16'hC123), 1'b0};
    idle_vecs[1] = '{16'h8000, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, mem_model(16'h8000), 1'b0};
    idle_vecs[2] = '{16'hFF80, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, hi_model(8'h80), 1'b0};
    idle_vecs[3] = '{16'hFF80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, hi_model(8'h80), 1'b0};
    idle_vecs[4] = '{16'hFF46, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    idle_vecs[5] = '{16'hFEFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, mem_model(16'hFEFF), 1'b0};
    idle_vecs[6] = '{16'hFF00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, hi_model(8'h00), 1'b0};
    idle_vecs[7] = '{16'hFFFF, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, hi_model(8'hFF), 1'b0};
    idle_vecs[8] = '{16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, mem_model(16'h0000), 1'b0};

    dma_vecs[0]  = '{16'h8000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1};
    dma_vecs[1]  = '{16'h8000, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1};
    dma_vecs[2]  = '{16'hFF80, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80, hi_model(8'h80), 1'b1};
    dma_vecs[3]  = '{16'hFF46, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hE3, 1'b1};
    dma_vecs[4]  = '{16'hFF80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, hi_model(8'h80), 1'b1};

    // Reset state, read back the DMA register while held in reset.
    cpu_idle();
    io.cpu_addr = DMA_REG_ADDR;
    io.cpu_re   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_active", io.dma_active, 1'b0);
    chk("reset_oam_we", io.oam_we, 1'b0);
    chk("reset_bus_re", io.bus_re, 1'b0);
    chk("reset_bus_we", io.bus_we, 1'b0);
    chk("reset_src_reg", io.cpu_rdata, 8'h00);
    reset_n = 1'b1;
    cpu_idle();
    next_cycle();

    $display("[TB] idle routing table");
    foreach (idle_vecs[i]) begin
      applyStimulus(idle_vecs[i]);
      @(negedge clk);
      checkOutput();
      next_cycle();
    end
    cpu_idle();

    $display("[TB] transfer from 0xC1");
    base = oam_pulses;
    start_dma(8'hC1);
    xfer_cycles(8'hC1, 0, LEN, 1'b0);
    finish_transfer("c1", LEN);

    $display("[TB] echo source 0xE3 with CPU traffic during DMA");
    base = oam_pulses;
    start_dma(8'hE3);
    xfer_cycles(8'hE3, 0, LEN, 1'b1);
    finish_transfer("e3", LEN);
    io.cpu_addr = DMA_REG_ADDR;
    io.cpu_re   = 1'b1;
    @(negedge clk);
    chk("readback_e3", io.cpu_rdata, 8'hE3);
    next_cycle();
    cpu_idle();

    $display("[TB] restart at idx 10");
    start_dma(8'hC2);
    xfer_cycles(8'hC2, 0, 10, 1'b0);
    io.cpu_addr  = DMA_REG_ADDR;
    io.cpu_wdata = 8'h80;
    io.cpu_we    = 1'b1;
    while (oam_q.size() > 1) void'(oam_q.pop_back());
    base = oam_pulses;
    @(negedge clk);
    chk("restart_bus_addr", io.bus_addr, 16'hC20A);
    next_cycle();
    io.cpu_wdata = 8'hC0;
    oam_q.delete();
    push_transfer(8'hC0);
    @(negedge clk);
    chk("restart_start_active", io.dma_active, 1'b0);
    next_cycle();
    cpu_idle();
    @(negedge clk);
    chk("restart2_start_active", io.dma_active, 1'b0);
    next_cycle();
    xfer_cycles(8'hC0, 0, LEN, 1'b0);
    finish_transfer("restart", LEN + 1);

    $display("[TB] reset during transfer");
    start_dma(8'hC4);
    xfer_cycles(8'hC4, 0, 50, 1'b0);
    io.cpu_addr = DMA_REG_ADDR;
    io.cpu_re   = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    oam_q.delete();
    base = oam_pulses;
    chk("midreset_active", io.dma_active, 1'b0);
    chk("midreset_oam_we", io.oam_we, 1'b0);
    chk("midreset_bus_re", io.bus_re, 1'b0);
    chk("midreset_bus_we", io.bus_we, 1'b0);
    chk("midreset_src_reg", io.cpu_rdata, 8'h00);
    cpu_idle();
    repeat (2) next_cycle();
    reset_n = 1'b1;
    repeat (170) next_cycle();
    chk("postreset_oam_pulses", oam_pulses - base, 0);
    chk("postreset_active", io.dma_active, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
